ls_cdb_producer: RTL and testbench

//  Load/store unit on the producer side of the CDB request/accept handshake.
//  - Accepts issued LW/SW, holds them in an in-order queue and snoops the CDB for missing operands.
//  - Performs the data-memory access.
//  - For loads, raises require and holds result+label until the CDBHelper grants requireAC.
//  - Occupies CDB slot 2 (require_s[2]/requireAC_s[2], data2/label2) in the Tomasulo core.

---
 rtl/ls_cdb_producer_pkg.sv | 32 +++
 rtl/ls_cdb_producer_if.sv | 34 +++
 rtl/ls_cdb_producer_dmem.sv | 24 ++
 rtl/ls_cdb_producer.sv | 194 +++++++++++++++++++
 tb/tb_ls_cdb_producer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ls_cdb_producer_pkg.sv
// Shared types and constants for the load/store CDB producer: opcodes, label
// encoding, FSM states and the queue entry layout.
package ls_cdb_producer_pkg;

  localparam int LABEL_W = 4;
  localparam logic [LABEL_W-1:0] LABEL_READY = 4'd0;

  localparam logic [1:0] LS_LW = 2'b00;
  localparam logic [1:0] LS_SW = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } ls_state_e;

  // A Q field of LABEL_READY means the matching data field holds the operand.
  typedef struct packed {
    logic               valid;
    logic [1:0]         op;
    logic [LABEL_W-1:0] base_q;
    logic [31:0]        base_d;
    logic [LABEL_W-1:0] data_q;
    logic [31:0]        data_d;
    logic [15:0]        immd;
  } ls_entry_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ls_cdb_producer_if.sv
// Issue, CDB snoop and CDB request/grant signals of the load/store unit.
// The issue stage / CDB side uses master; the load/store unit uses slave.
interface ls_cdb_producer_if;
  import ls_cdb_producer_pkg::*;

  logic               WEN;
  logic [1:0]         opCode;
  logic [31:0]        baseData;
  logic [LABEL_W-1:0] baseLabel;
  logic [31:0]        stData;
  logic [LABEL_W-1:0] stLabel;
  logic [15:0]        immd16;
  logic               BCEN;
  logic [LABEL_W-1:0] BClabel;
  logic [31:0]        BCdata;
  logic               requireAC;
  logic               isFull;
  logic [LABEL_W-1:0] nextLabel;
  logic               require;
  logic [31:0]        dataOut;
  logic [LABEL_W-1:0] labelOut;

  modport master (
    output WEN, opCode, baseData, baseLabel, stData, stLabel, immd16,
    output BCEN, BClabel, BCdata, requireAC,
    input  isFull, nextLabel, require, dataOut, labelOut
  );

  modport slave (
    input  WEN, opCode, baseData, baseLabel, stData, stLabel, immd16,
    input  BCEN, BClabel, BCdata, requireAC,
    output isFull, nextLabel, require, dataOut, labelOut
  );
endinterface

// File: rtl/ls_cdb_producer_dmem.sv
// Data memory of the load/store unit: synchronous write, asynchronous read.
// Contents are deliberately left unreset.
module ls_dmem #(
  parameter int MEM_WORDS = 256,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ls_cdb_producer.sv
// In-order load/store queue that snoops the CDB for operands, accesses data
// memory and holds load results on the CDB until the grant arrives.
module ls_cdb_producer
  import ls_cdb_producer_pkg::*;
#(
  parameter int                 DEPTH       = 4,
  parameter logic [LABEL_W-1:0] LABEL_BASE  = 4'd12,
  parameter int                 MEM_LATENCY = 2,
  parameter int                 MEM_WORDS   = 256
) (
  input  logic              clk,
  input  logic              nRST,
  ls_cdb_producer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AW    = $clog2(MEM_WORDS);
  localparam int CTR_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  ls_state_e          state_reg, state_next;
  logic [CTR_W-1:0]   ctr_reg, ctr_next;
  logic               require_reg, require_next;
  logic [31:0]        data_out_reg, data_out_next;
  logic [LABEL_W-1:0] label_out_reg, label_out_next;
  logic [PTR_W-1:0]   head_reg, tail_reg;
  logic [CNT_W-1:0]   count_reg;

  ls_entry_t          entry_q [DEPTH];
  ls_entry_t          issue_entry;
  ls_entry_t          head;
  logic               is_full, issue, pop, head_ready, mem_we;
  logic [31:0]        head_addr, mem_rdata;
  logic [AW-1:0]      mem_word;
  logic [LABEL_W-1:0] head_label;
  logic               unused_addr_bits;

  assign is_full    = (count_reg == CNT_W'(DEPTH));
  assign issue      = bus.WEN && !is_full;
  assign head       = entry_q[head_reg];
  assign head_label = LABEL_BASE + LABEL_W'(head_reg);
  assign head_ready = head.valid && (head.base_q == LABEL_READY) &&
                      ((head.op != LS_SW) || (head.data_q == LABEL_READY));
  assign head_addr  = head.base_d + sext16(head.immd);
  assign mem_word   = head_addr[AW+1:2];
  assign unused_addr_bits = ^{head_addr[31:AW+2], head_addr[1:0]};

  // A broadcast landing in the issue cycle is folded in here, since the
  // entry does not exist yet to snoop it.
  always_comb begin
    issue_entry        = '0;
    issue_entry.valid  = 1'b1;
    issue_entry.op     = bus.opCode;
    issue_entry.base_q = bus.baseLabel;
    issue_entry.base_d = bus.baseData;
    issue_entry.data_q = bus.stLabel;
    issue_entry.data_d = bus.stData;
    issue_entry.immd   = bus.immd16;
    if (bus.BCEN && bus.baseLabel != LABEL_READY && bus.BClabel == bus.baseLabel) begin
      issue_entry.base_q = LABEL_READY;
      issue_entry.base_d = bus.BCdata;
    end
    if (bus.BCEN && bus.stLabel != LABEL_READY && bus.BClabel == bus.stLabel) begin
      issue_entry.data_q = LABEL_READY;
      issue_entry.data_d = bus.BCdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      ls_entry_t entry_reg, entry_next;

      always_comb begin
        entry_next = entry_reg;
        if (issue && tail_reg == PTR_W'(gi)) begin
          entry_next = issue_entry;
        end else begin
          if (pop && head_reg == PTR_W'(gi)) begin
            entry_next.valid = 1'b0;
          end
          if (bus.BCEN && entry_reg.valid) begin
            if (entry_reg.base_q != LABEL_READY && entry_reg.base_q == bus.BClabel) begin
              entry_next.base_q = LABEL_READY;
              entry_next.base_d = bus.BCdata;
            end
            if (entry_reg.data_q != LABEL_READY && entry_reg.data_q == bus.BClabel) begin
              entry_next.data_q = LABEL_READY;
              entry_next.data_d = bus.BCdata;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
          entry_reg <= '0;
        end else begin
          entry_reg <= entry_next;
        end
      end

      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  ls_dmem #(.MEM_WORDS(MEM_WORDS)) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_word),
    .wdata (head.data_d),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_next     = state_reg;
    ctr_next       = ctr_reg;
    require_next   = require_reg;
    data_out_next  = data_out_reg;
    label_out_next = label_out_reg;
    pop            = 1'b0;
    mem_we         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (head_ready) begin
          state_next = ST_MEM;
          ctr_next   = CTR_W'(MEM_LATENCY - 1);
        end
      end
      ST_MEM: begin
        if (ctr_reg == '0) begin
          if (head.op == LS_LW) begin
            data_out_next  = mem_rdata;
            label_out_next = head_label;
            require_next   = 1'b1;
            state_next     = ST_WB;
          end else begin
            // Stores write here; reserved opcodes just retire silently.
            mem_we     = (head.op == LS_SW);
            pop        = 1'b1;
            state_next = ST_IDLE;
          end
        end else begin
          ctr_next = ctr_reg - CTR_W'(1);
        end
      end
      ST_WB: begin
        if (bus.requireAC) begin
          require_next = 1'b0;
          pop          = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_reg     <= ST_IDLE;
      ctr_reg       <= '0;
      require_reg   <= 1'b0;
      data_out_reg  <= '0;
      label_out_reg <= LABEL_READY;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      ctr_reg       <= ctr_next;
      require_reg   <= require_next;
      data_out_reg  <= data_out_next;
      label_out_reg <= label_out_next;
      if (pop) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      if (issue) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (issue && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !issue) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  assign bus.isFull    = is_full;
  assign bus.nextLabel = LABEL_BASE + LABEL_W'(tail_reg);
  assign bus.require   = require_reg;
  assign bus.dataOut   = data_out_reg;
  assign bus.labelOut  = label_out_reg;

endmodule

// File: tb/tb_ls_cdb_producer.sv
// Directed bench for ls_cdb_producer: a store/load vector table plus
// hand-written sequences for snoop, hold, full queue, reserved ops and reset.
module tb_ls_cdb_producer;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  int   tests = 0;
  int   fails = 0;

  ls_cdb_producer_if bus();

  ls_cdb_producer dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] base;
    logic [15:0] imm;
    logic [31:0] st_data;
    logic [31:0] exp_data;
    logic [3:0]  exp_label;
  } vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  blab;
    logic [31:0] base;
    logic [15:0] imm;
    logic [31:0] st_data;
    logic        exp_full;
    logic [3:0]  exp_next;
  } fill_t;

  vec_t  vecs [11];
  fill_t fills [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] base, input logic [3:0] blab,
                       input logic [31:0] sd, input logic [3:0] slab, input logic [15:0] imm);
    @(negedge clk);
    bus.WEN = 1'b1; bus.opCode = op; bus.baseData = base; bus.baseLabel = blab;
    bus.stData = sd; bus.stLabel = slab; bus.immd16 = imm;
    @(posedge clk); #1;
    bus.WEN = 1'b0;
  endtask

  task automatic broadcast(input logic [3:0] lab, input logic [31:0] d);
    @(negedge clk);
    bus.BCEN = 1'b1; bus.BClabel = lab; bus.BCdata = d;
    @(posedge clk); #1;
    bus.BCEN = 1'b0;
  endtask

  // Edges counted from the issuing/waking edge until require is seen high.
  task automatic wait_require(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.require && n < 20);
  endtask

  task automatic grant();
    bus.requireAC = 1'b1;
    @(posedge clk); #1;
    bus.requireAC = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // SW/LW table: word = (base + sext(imm))[9:2]; labels 12 + issue_index % 4.
    vecs[0]  = '{2'b01, 32'h0000_0010, 16'h0004, 32'hA5A5_A5A5, 32'h0,         4'd12}; // word 5
    vecs[1]  = '{2'b00, 32'h0000_0014, 16'h0000, 32'h0,         32'hA5A5_A5A5, 4'd13};
    vecs[2]  = '{2'b01, 32'h0000_0100, 16'hFFFC, 32'h1111_1111, 32'h0,         4'd14}; // word 63
    vecs[3]  = '{2'b01, 32'h0000_0403, 16'h0008, 32'h2222_2222, 32'h0,         4'd15}; // word 2
    vecs[4]  = '{2'b01, 32'h0000_0000, 16'h7FFC, 32'h3333_3333, 32'h0,         4'd12}; // word 255
    vecs[5]  = '{2'b01, 32'hFFFF_FFF0, 16'h0010, 32'h4444_4444, 32'h0,         4'd13}; // word 0
    vecs[6]  = '{2'b00, 32'h0000_00FE, 16'h0000, 32'h0,         32'h1111_1111, 4'd14};
    vecs[7]  = '{2'b00, 32'h0000_0008, 16'h0000, 32'h0,         32'h2222_2222, 4'd15};
    vecs[8]  = '{2'b00, 32'h0000_03FC, 16'h0000, 32'h0,         32'h3333_3333, 4'd12};
    vecs[9]  = '{2'b00, 32'h0000_0010, 16'hFFF0, 32'h0,         32'h4444_4444, 4'd13};
    vecs[10] = '{2'b00, 32'h0000_0400, 16'h0014, 32'h0,         32'hA5A5_A5A5, 4'd14};

    // Back-to-back fill with a blocked head; the fifth op must be dropped.
    fills[0] = '{2'b00, 4'd7, 32'h0000_0000, 16'h0014, 32'h0,         1'b0, 4'd13};
    fills[1] = '{2'b01, 4'd0, 32'h0000_0028, 16'h0000, 32'h1010_1010, 1'b0, 4'd14};
    fills[2] = '{2'b01, 4'd0, 32'h0000_002C, 16'h0000, 32'h2020_2020, 1'b0, 4'd15};
    fills[3] = '{2'b01, 4'd0, 32'h0000_0030, 16'h0000, 32'h3030_3030, 1'b1, 4'd12};
    fills[4] = '{2'b01, 4'd0, 32'h0000_002C, 16'h0000, 32'hBAD0_BAD0, 1'b1, 4'd12};

    bus.WEN = 0; bus.opCode = 0; bus.baseData = 0; bus.baseLabel = 0; bus.stData = 0;
    bus.stLabel = 0; bus.immd16 = 0; bus.BCEN = 0; bus.BClabel = 0; bus.BCdata = 0;
    bus.requireAC = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); nRST = 1'b1;
    @(posedge clk); #1;

    check("reset require", 32'(bus.require), 32'd0);
    check("reset isFull", 32'(bus.isFull), 32'd0);
    check("reset nextLabel", 32'(bus.nextLabel), 32'd12);
    check("reset dataOut", bus.dataOut, 32'd0);
    check("reset labelOut", 32'(bus.labelOut), 32'd0);

    for (int k = 0; k < 11; k++) begin
      check($sformatf("v%0d nextLabel", k), 32'(bus.nextLabel), 32'(vecs[k].exp_label));
      issue(vecs[k].op, vecs[k].base, 4'd0, vecs[k].st_data, 4'd0, vecs[k].imm);
      if (vecs[k].op == 2'b00) begin
        wait_require(n);
        check($sformatf("v%0d latency", k), 32'(n), 32'd3);
        check($sformatf("v%0d dataOut", k), bus.dataOut, vecs[k].exp_data);
        check($sformatf("v%0d labelOut", k), 32'(bus.labelOut), 32'(vecs[k].exp_label));
        grant();
        check($sformatf("v%0d require after grant", k), 32'(bus.require), 32'd0);
      end else begin
        repeat (4) @(posedge clk);
        #1;
        check($sformatf("v%0d store no require", k), 32'(bus.require), 32'd0);
      end
    end

    // Store to word 8, then a load whose base arrives on the CDB later.
    check("snoop nextLabel sw", 32'(bus.nextLabel), 32'd15);
    issue(2'b01, 32'h0000_001C, 4'd0, 32'h0BAD_F00D, 4'd0, 16'h0004);
    repeat (4) @(posedge clk);
    #1;
    check("snoop nextLabel lw", 32'(bus.nextLabel), 32'd12);
    issue(2'b00, 32'hDEAD_0000, 4'd3, 32'h0, 4'd0, 16'h0000);
    repeat (5) @(posedge clk);
    #1;
    check("snoop blocked require", 32'(bus.require), 32'd0);
    broadcast(4'd3, 32'h0000_0020);
    wait_require(n);
    check("snoop latency", 32'(n), 32'd3);
    check("snoop dataOut", bus.dataOut, 32'h0BAD_F00D);
    check("snoop labelOut", 32'(bus.labelOut), 32'd12);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d require", c), 32'(bus.require), 32'd1);
      check($sformatf("hold%0d dataOut", c), bus.dataOut, 32'h0BAD_F00D);
      check($sformatf("hold%0d labelOut", c), 32'(bus.labelOut), 32'd12);
    end
    grant();
    check("hold require after grant", 32'(bus.require), 32'd0);

    // Broadcast in the issue cycle itself.
    check("bypass nextLabel", 32'(bus.nextLabel), 32'd13);
    @(negedge clk);
    bus.WEN = 1'b1; bus.opCode = 2'b00; bus.baseData = 32'hDEAD_0000; bus.baseLabel = 4'd5;
    bus.stLabel = 4'd0; bus.immd16 = 16'h0000;
    bus.BCEN = 1'b1; bus.BClabel = 4'd5; bus.BCdata = 32'h0000_0020;
    @(posedge clk); #1;
    bus.WEN = 1'b0; bus.BCEN = 1'b0; bus.baseLabel = 4'd0;
    wait_require(n);
    check("bypass latency", 32'(n), 32'd3);
    check("bypass dataOut", bus.dataOut, 32'h0BAD_F00D);
    check("bypass labelOut", 32'(bus.labelOut), 32'd13);
    grant();

    // Reserved opcodes aimed at word 8 must neither write nor request.
    for (int r = 0; r < 2; r++) begin
      issue(2'b10 + 2'(r), 32'h0000_0020, 4'd0, 32'hFFFF_FFFF, 4'd0, 16'h0000);
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("reserved%0d require", r), 32'(bus.require), 32'd0);
    end

    check("fill start nextLabel", 32'(bus.nextLabel), 32'd12);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.WEN = 1'b1; bus.opCode = fills[k].op; bus.baseLabel = fills[k].blab;
      bus.baseData = fills[k].base; bus.immd16 = fills[k].imm;
      bus.stData = fills[k].st_data; bus.stLabel = 4'd0;
      @(posedge clk); #1;
      check($sformatf("fill%0d isFull", k), 32'(bus.isFull), 32'(fills[k].exp_full));
      check($sformatf("fill%0d nextLabel", k), 32'(bus.nextLabel), 32'(fills[k].exp_next));
    end
    @(negedge clk);
    bus.WEN = 1'b0; bus.baseLabel = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("fill blocked require", 32'(bus.require), 32'd0);
    broadcast(4'd7, 32'h0000_0000);
    wait_require(n);
    check("fill latency", 32'(n), 32'd3);
    check("fill dataOut", bus.dataOut, 32'hA5A5_A5A5);
    check("fill labelOut", 32'(bus.labelOut), 32'd12);
    check("fill isFull in WB", 32'(bus.isFull), 32'd1);
    // Grant and a competing issue on the same edge while full.
    bus.requireAC = 1'b1;
    bus.WEN = 1'b1; bus.opCode = 2'b01; bus.baseData = 32'h0000_002C;
    bus.immd16 = 16'h0000; bus.stData = 32'hBAD1_BAD1; bus.stLabel = 4'd0;
    @(posedge clk); #1;
    bus.requireAC = 1'b0; bus.WEN = 1'b0;
    check("pop+issue full require", 32'(bus.require), 32'd0);
    check("pop+issue full isFull", 32'(bus.isFull), 32'd0);
    check("pop+issue full nextLabel", 32'(bus.nextLabel), 32'd12);
    repeat (12) @(posedge clk);
    #1;
    check("drain isFull", 32'(bus.isFull), 32'd0);
    issue(2'b00, 32'h0000_002C, 4'd0, 32'h0, 4'd0, 16'h0000);
    wait_require(n);
    check("drain latency", 32'(n), 32'd3);
    check("drain dataOut", bus.dataOut, 32'h2020_2020);
    check("drain labelOut", 32'(bus.labelOut), 32'd12);
    grant();

    // Asynchronous reset while holding a load on the CDB.
    check("rst seq nextLabel", 32'(bus.nextLabel), 32'd13);
    issue(2'b00, 32'h0000_0020, 4'd0, 32'h0, 4'd0, 16'h0000);
    wait_require(n);
    check("rst seq latency", 32'(n), 32'd3);
    check("rst seq dataOut", bus.dataOut, 32'h0BAD_F00D);
    nRST = 1'b0;
    #1;
    check("async rst require", 32'(bus.require), 32'd0);
    check("async rst isFull", 32'(bus.isFull), 32'd0);
    check("async rst nextLabel", 32'(bus.nextLabel), 32'd12);
    check("async rst labelOut", 32'(bus.labelOut), 32'd0);
    @(negedge clk); nRST = 1'b1;
    @(posedge clk); #1;
    issue(2'b00, 32'h0000_002C, 4'd0, 32'h0, 4'd0, 16'h0000);
    wait_require(n);
    check("post rst latency", 32'(n), 32'd3);
    check("post rst dataOut", bus.dataOut, 32'h2020_2020);
    check("post rst labelOut", 32'(bus.labelOut), 32'd12);
    grant();
    check("post rst require", 32'(bus.require), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
